// File: rtl/fm_radio_pkg.sv
// Shared constants, arithmetic helpers and state encoding for the FM demodulator.
// All data paths are 32-bit signed Q10 fixed point.
package fm_radio_pkg;

   localparam int unsigned DATA_W     = 32;
   localparam int unsigned PROD_W     = 64;
   localparam int unsigned QUANT_BITS = 10;
   localparam int unsigned DIV_ITERS  = 32;

   localparam logic signed [DATA_W-1:0] QUARTER_PI       = 32'sd804;
   localparam logic signed [DATA_W-1:0] THREE_QUARTER_PI = 32'sd2412;
   localparam int                       FM_DEMOD_GAIN    = 758;

   typedef enum logic [2:0] {
      S_READ,
      S_MULT,
      S_DIV_START,
      S_DIV_WAIT,
      S_SCALE,
      S_WRITE
   } demod_state_e;

   // Full-precision signed product of two data words.
   function automatic logic signed [PROD_W-1:0] smul(input logic signed [DATA_W-1:0] a,
                                                     input logic signed [DATA_W-1:0] b);
      logic signed [PROD_W-1:0] ae;
      logic signed [PROD_W-1:0] be;
      ae = PROD_W'(a);
      be = PROD_W'(b);
      return ae * be;
   endfunction

   // Dequantize: arithmetic shift out the fraction bits, keep the low word.
   function automatic logic signed [DATA_W-1:0] dq(input logic signed [PROD_W-1:0] p,
                                                   input int unsigned            qb);
      return DATA_W'(p >>> qb);
   endfunction

   // Unsigned magnitude; the most negative value maps to 2^31 exactly.
   function automatic logic [DATA_W-1:0] mag(input logic signed [DATA_W-1:0] x);
      return x[DATA_W-1] ? DATA_W'(-x) : DATA_W'(x);
   endfunction

endpackage

// File: rtl/demodulate_if.sv
// FIFO-side bundle of the demodulator: complex input pops and the output push.
interface demodulate_if;
   import fm_radio_pkg::*;

   logic signed [DATA_W-1:0] real_in;
   logic signed [DATA_W-1:0] imag_in;
   logic                     real_empty;
   logic                     imag_empty;
   logic                     real_rd_en;
   logic                     imag_rd_en;
   logic signed [DATA_W-1:0] demod_out;
   logic                     demod_wr_en;
   logic                     demod_full;

   modport master (
      input  real_in, imag_in, real_empty, imag_empty, demod_full,
      output real_rd_en, imag_rd_en, demod_out, demod_wr_en
   );

   modport slave (
      output real_in, imag_in, real_empty, imag_empty, demod_full,
      input  real_rd_en, imag_rd_en, demod_out, demod_wr_en
   );

endinterface

// File: rtl/demodulate_div.sv
// Iterative radix-2 restoring signed divider, truncating toward zero.
// done_o is high during the last of the DIV_ITERS iteration cycles.
module div
   import fm_radio_pkg::*;
(
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     start_i,
   input  logic signed [DATA_W-1:0] dividend_i,
   input  logic signed [DATA_W-1:0] divisor_i,
   output logic                     busy_o,
   output logic                     done_o,
   output logic signed [DATA_W-1:0] quotient_o
);

   localparam int unsigned CNT_W = $clog2(DIV_ITERS + 1);

   logic              busy_q, busy_d, done_q, done_d;
   logic              neg_q, neg_d, zero_q, zero_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
   logic [DATA_W:0]   rem_sh, trial;

   always_comb begin
      busy_d = busy_q;
      done_d = done_q;
      neg_d  = neg_q;
      zero_d = zero_q;
      cnt_d  = cnt_q;
      quo_d  = quo_q;
      rem_d  = rem_q;
      dvs_d  = dvs_q;
      rem_sh = {rem_q, quo_q[DATA_W-1]};
      trial  = rem_sh - {1'b0, dvs_q};
      if (busy_q) begin
         if (trial[DATA_W]) begin
            rem_d = rem_sh[DATA_W-1:0];
            quo_d = {quo_q[DATA_W-2:0], 1'b0};
         end else begin
            rem_d = trial[DATA_W-1:0];
            quo_d = {quo_q[DATA_W-2:0], 1'b1};
         end
         cnt_d  = cnt_q - CNT_W'(1);
         done_d = (cnt_q == CNT_W'(2));
         if (cnt_q == CNT_W'(1)) begin
            busy_d = 1'b0;
            done_d = 1'b0;
         end
      end else if (start_i) begin
         busy_d = 1'b1;
         done_d = 1'b0;
         cnt_d  = CNT_W'(DIV_ITERS);
         quo_d  = mag(dividend_i);
         rem_d  = '0;
         dvs_d  = mag(divisor_i);
         neg_d  = dividend_i[DATA_W-1] ^ divisor_i[DATA_W-1];
         zero_d = (divisor_i == '0);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         busy_q <= 1'b0;
         done_q <= 1'b0;
         neg_q  <= 1'b0;
         zero_q <= 1'b0;
         cnt_q  <= '0;
         quo_q  <= '0;
         rem_q  <= '0;
         dvs_q  <= '0;
      end else begin
         busy_q <= busy_d;
         done_q <= done_d;
         neg_q  <= neg_d;
         zero_q <= zero_d;
         cnt_q  <= cnt_d;
         quo_q  <= quo_d;
         rem_q  <= rem_d;
         dvs_q  <= dvs_d;
      end
   end

   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign quotient_o = zero_q ? '0 : (neg_q ? DATA_W'(-quo_q) : quo_q);

endmodule

// File: rtl/demodulate.sv
// FM discriminator: conjugate-multiplies each sample with the previous one and
// converts the phase step to an amplitude via a divider-based atan approximation.
module demodulate
   import fm_radio_pkg::*;
#(
   parameter int          GAIN       = FM_DEMOD_GAIN,
   parameter int unsigned QUANT_BITS = fm_radio_pkg::QUANT_BITS
)(
   input logic          clock,
   input logic          reset,
   demodulate_if.master bus
);

   localparam logic signed [DATA_W-1:0] GAIN_S = DATA_W'(GAIN);

   demod_state_e             state_q, state_d;
   logic signed [DATA_W-1:0] cur_r_q, cur_r_d, cur_i_q, cur_i_d;
   logic signed [DATA_W-1:0] prev_r_q, prev_r_d, prev_i_q, prev_i_d;
   logic signed [DATA_W-1:0] r_q, r_d, i_q, i_d;
   logic signed [DATA_W-1:0] base_q, base_d, result_q, result_d;
   logic                     ready_q;

   logic                     r_nonneg;
   logic signed [DATA_W-1:0] abs_y, diff, num, den, quot, angle_raw, angle;
   logic                     rd_en_c, wr_en_c, div_start, div_busy, div_done;

   // Divider operands and the final angle, all wrapping 32-bit arithmetic.
   assign r_nonneg  = !r_q[DATA_W-1];
   assign abs_y     = $signed(mag(i_q)) + 32'sd1;
   assign diff      = r_nonneg ? (r_q - abs_y) : (r_q + abs_y);
   assign num       = QUARTER_PI * (diff <<< QUANT_BITS);
   assign den       = r_nonneg ? (r_q + abs_y) : (abs_y - r_q);
   assign angle_raw = base_q - (quot >>> QUANT_BITS);
   assign angle     = i_q[DATA_W-1] ? -angle_raw : angle_raw;

   always_comb begin
      state_d   = state_q;
      cur_r_d   = cur_r_q;
      cur_i_d   = cur_i_q;
      prev_r_d  = prev_r_q;
      prev_i_d  = prev_i_q;
      r_d       = r_q;
      i_d       = i_q;
      base_d    = base_q;
      result_d  = result_q;
      rd_en_c   = 1'b0;
      wr_en_c   = 1'b0;
      div_start = 1'b0;
      case (state_q)
         S_READ: begin
            // ready_q keeps strobes low in the first cycle out of reset.
            if (ready_q && !reset && !bus.real_empty && !bus.imag_empty) begin
               rd_en_c = 1'b1;
               cur_r_d = bus.real_in;
               cur_i_d = bus.imag_in;
               state_d = S_MULT;
            end
         end
         S_MULT: begin
            r_d      = dq(smul(prev_r_q, cur_r_q), QUANT_BITS) + dq(smul(prev_i_q, cur_i_q), QUANT_BITS);
            i_d      = dq(smul(prev_r_q, cur_i_q), QUANT_BITS) - dq(smul(prev_i_q, cur_r_q), QUANT_BITS);
            prev_r_d = cur_r_q;
            prev_i_d = cur_i_q;
            state_d  = S_DIV_START;
         end
         S_DIV_START: begin
            if (!div_busy) begin
               div_start = 1'b1;
               base_d    = r_nonneg ? QUARTER_PI : THREE_QUARTER_PI;
               state_d   = S_DIV_WAIT;
            end
         end
         S_DIV_WAIT: begin
            if (div_done) state_d = S_SCALE;
         end
         S_SCALE: begin
            result_d = dq(smul(GAIN_S, angle), QUANT_BITS);
            state_d  = S_WRITE;
         end
         S_WRITE: begin
            if (!bus.demod_full && !reset) begin
               wr_en_c = 1'b1;
               state_d = S_READ;
            end
         end
         default: state_d = S_READ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= S_READ;
         ready_q  <= 1'b0;
         cur_r_q  <= '0;
         cur_i_q  <= '0;
         prev_r_q <= '0;
         prev_i_q <= '0;
         r_q      <= '0;
         i_q      <= '0;
         base_q   <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         ready_q  <= 1'b1;
         cur_r_q  <= cur_r_d;
         cur_i_q  <= cur_i_d;
         prev_r_q <= prev_r_d;
         prev_i_q <= prev_i_d;
         r_q      <= r_d;
         i_q      <= i_d;
         base_q   <= base_d;
         result_q <= result_d;
      end
   end

   div u_div (
      .clock      (clock),
      .reset      (reset),
      .start_i    (div_start),
      .dividend_i (num),
      .divisor_i  (den),
      .busy_o     (div_busy),
      .done_o     (div_done),
      .quotient_o (quot)
   );

   assign bus.real_rd_en  = rd_en_c;
   assign bus.imag_rd_en  = rd_en_c;
   assign bus.demod_wr_en = wr_en_c;
   assign bus.demod_out   = result_q;

endmodule

// File: tb/tb_demodulate.sv
// Directed bench for demodulate: hand-computed outputs, latency, stall and reset behaviour.
module tb_demodulate;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   demodulate_if bus();

   demodulate #(.GAIN(758), .QUANT_BITS(10)) dut (
      .clock (clk),
      .reset (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic to_cycle(input int c);
      while (cyc < c) @(negedge clk);
      #1;
   endtask

   // Present one sample, wait for the pop, then mark the FIFOs empty again.
   task automatic feed(input string tag, input logic signed [31:0] r, input logic signed [31:0] im,
                       output int t_rd);
      bit seen = 1'b0;
      t_rd = -1;
      @(negedge clk);
      bus.real_in    = r;
      bus.imag_in    = im;
      bus.real_empty = 1'b0;
      bus.imag_empty = 1'b0;
      #1;
      for (int n = 0; n < 100; n++) begin
         if (bus.real_rd_en && bus.imag_rd_en) begin
            seen = 1'b1;
            t_rd = cyc;
            break;
         end
         @(negedge clk);
         #1;
      end
      chk({tag, "_pop"}, 32'(seen), 32'sd1);
      @(posedge clk);
      #1;
      bus.real_empty = 1'b1;
      bus.imag_empty = 1'b1;
   endtask

   task automatic wait_write(input string tag, input int t_rd, input logic signed [31:0] expv);
      int t_wr = -1;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         #1;
         if (bus.demod_wr_en) begin
            t_wr = cyc;
            break;
         end
      end
      chk({tag, "_lat"}, t_wr - t_rd, 32'sd36);
      chk({tag, "_val"}, bus.demod_out, expv);
      @(negedge clk);
      #1;
      chk({tag, "_single"}, 32'(bus.demod_wr_en), 32'sd0);
      chk({tag, "_hold"}, bus.demod_out, expv);
   endtask

   initial begin
      int t;
      int bad;

      // Data already waiting while reset is held.
      bus.real_in    = 32'sd1024;
      bus.imag_in    = 32'sd0;
      bus.real_empty = 1'b0;
      bus.imag_empty = 1'b0;
      bus.demod_full = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_rd_en", 32'(bus.real_rd_en | bus.imag_rd_en), 32'sd0);
      chk("rst_wr_en", 32'(bus.demod_wr_en), 32'sd0);
      chk("rst_out", bus.demod_out, 32'sd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("post_rst_rd_en", 32'(bus.real_rd_en | bus.imag_rd_en), 32'sd0);
      chk("post_rst_out", bus.demod_out, 32'sd0);

      feed("s1", 32'sd1024, 32'sd0, t);
      wait_write("s1", t, 32'sd1190);

      // Only one FIFO has data: nothing may be popped.
      @(negedge clk);
      bus.real_in    = 32'sd555;
      bus.imag_in    = 32'sd333;
      bus.real_empty = 1'b0;
      bus.imag_empty = 1'b1;
      bad = 0;
      repeat (20) begin
         #1;
         if (bus.real_rd_en || bus.imag_rd_en || bus.demod_wr_en) bad++;
         @(negedge clk);
      end
      chk("real_only_no_rd", bad, 32'sd0);
      bus.real_empty = 1'b1;
      bus.imag_empty = 1'b0;
      bad = 0;
      repeat (10) begin
         #1;
         if (bus.real_rd_en || bus.imag_rd_en || bus.demod_wr_en) bad++;
         @(negedge clk);
      end
      chk("imag_only_no_rd", bad, 32'sd0);
      bus.imag_empty = 1'b1;

      feed("s2", 32'sd1024, 32'sd0, t);
      wait_write("s2", t, 32'sd1);
      feed("s3", 32'sd0, 32'sd1024, t);
      wait_write("s3", t, 32'sd1190);
      feed("s4", 32'sd1024, 32'sd0, t);
      wait_write("s4", t, -32'sd1191);
      feed("s5", 32'sd0, -32'sd1024, t);
      wait_write("s5", t, -32'sd1191);

      // Output full for the whole computation plus 10 cycles in S_WRITE.
      bus.demod_full = 1'b1;
      feed("stall", 32'sd1024, 32'sd0, t);
      to_cycle(t + 36);
      chk("stall_first_no_wr", 32'(bus.demod_wr_en), 32'sd0);
      chk("stall_first_out", bus.demod_out, 32'sd1190);
      to_cycle(t + 45);
      chk("stall_last_no_wr", 32'(bus.demod_wr_en), 32'sd0);
      chk("stall_last_out", bus.demod_out, 32'sd1190);
      @(negedge clk);
      bus.demod_full = 1'b0;
      #1;
      chk("stall_release_wr", 32'(bus.demod_wr_en), 32'sd1);
      chk("stall_release_cyc", cyc - t, 32'sd46);
      chk("stall_release_out", bus.demod_out, 32'sd1190);
      @(negedge clk);
      #1;
      chk("stall_single", 32'(bus.demod_wr_en), 32'sd0);

      // Reset 15 cycles into a sample: it must vanish without a write.
      feed("midrst", 32'sd0, 32'sd1024, t);
      to_cycle(t + 15);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("midrst_out", bus.demod_out, 32'sd0);
      chk("midrst_rd_en", 32'(bus.real_rd_en | bus.imag_rd_en), 32'sd0);
      bad = 0;
      repeat (60) begin
         @(negedge clk);
         #1;
         if (bus.demod_wr_en) bad++;
      end
      chk("midrst_no_write", bad, 32'sd0);

      feed("after_rst", 32'sd1024, 32'sd0, t);
      wait_write("after_rst", t, 32'sd1190);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/demodulate.md
DEMODULATE -- requirements
Module: demodulate

Interface
REQ-001 SHALL have parameter GAIN, default 758 (FM_DEMOD_GAIN): output scale factor, Q10.
REQ-002 SHALL have parameter QUANT_BITS, default 10: fixed-point fraction bits.
REQ-003 SHALL have port clock  in  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports real_in / imag_in  in  32 each  signed Q10 complex sample from upstream fir_cmplx output FIFOs.
REQ-006 SHALL have ports real_empty / imag_empty  in  1 each  upstream FIFO empty flags.
REQ-007 SHALL have ports real_rd_en / imag_rd_en  out  1 each  FIFO pop strobes.
REQ-008 SHALL have port demod_out  out  32  signed demodulated sample.
REQ-009 SHALL have port demod_wr_en  out  1  output FIFO push strobe.
REQ-010 SHALL have port demod_full  in  1  output FIFO full flag.

Function
REQ-011 SHALL use FSM states S_READ, S_MULT, S_DIV_START, S_DIV_WAIT, S_SCALE, S_WRITE.
REQ-012 S_READ: when real_empty=0 AND imag_empty=0, SHALL assert real_rd_en and imag_rd_en together for one cycle, latch cur=(real_in, imag_in), go S_MULT; otherwise hold, both rd_en=0.
REQ-013 S_MULT: r = dq(prev_r*cur_r) + dq(prev_i*cur_i); i = dq(prev_r*cur_i) - dq(prev_i*cur_r); dq(p) = low 32 bits of (64-bit signed product >>> 10); then prev <= cur.
REQ-014 S_DIV_START: abs_y = |i|+1; if r>=0: num = 804*((r-abs_y)<<10), den = r+abs_y, base = 804; else num = 804*((r+abs_y)<<10), den = abs_y-r, base = 2412; all 32-bit signed, wrapping.
REQ-015 Division SHALL be signed, truncate toward zero, occupy S_DIV_WAIT for exactly 32 cycles; den=0 SHALL yield quotient 0 (unreachable by construction, still required).
REQ-016 S_SCALE: angle = base - (q >>> 10); negate if i<0; result = dq(GAIN*angle).
REQ-017 S_WRITE: when demod_full=0, SHALL assert demod_wr_en one cycle with demod_out=result, return S_READ; while full, hold, wr_en=0, demod_out stable.
REQ-018 Latency: rd_en in cycle T SHALL give demod_wr_en in cycle T+36 when output not full.
REQ-019 Throughput: one sample per 37 cycles minimum; no overlap of samples.
REQ-020 One empty flag low, other high: SHALL NOT read either FIFO.
REQ-021 demod_full asserted during computation SHALL NOT stall it; stall only in S_WRITE.
REQ-022 demod_out SHALL be driven in every state (holds last written value), never X.

Reset
REQ-023 reset=1 at a clock edge SHALL force state S_READ, prev=(0,0), result=0, demod_out=0, all rd_en/wr_en=0, divider idle.
REQ-024 Reset mid-operation SHALL discard the in-flight sample with no write; first post-reset sample uses prev=(0,0).
REQ-025 Outputs SHALL be valid (0 strobes) in the first cycle after reset deasserts.

Structure
REQ-026 Package fm_radio_pkg SHALL hold QUANT_BITS, QUARTER_PI=804, THREE_QUARTER_PI=2412, FM_DEMOD_GAIN=758, dq function, demod state typedef.
REQ-027 SHALL instantiate one sub-module div: 32-bit signed iterative radix-2 divider with start/busy/done, 32 iteration cycles.

Verification
REQ-028 Reset, then cur=(1024,0) with prev=0 -> demod_out=1190.
REQ-029 Next cur=(1024,0) -> demod_out=1; then cur=(0,1024) after prev=(1024,0) -> 1190.
REQ-030 prev=(1024,0), cur=(0,-1024) -> demod_out=-1191 (negation before floor shift).
REQ-031 Input appears at T -> wr_en exactly T+36; hold demod_full=1 for 10 cycles -> single write 10 cycles later, value unchanged.
REQ-032 real_empty=0, imag_empty=1 for 20 cycles -> no rd_en; reset at T+15 of a sample -> no write, next sample from (1024,0) gives 1190.
